// File: rtl/mac_dot_collector.sv
// Dot-product collector behind an accumulating MAC: counts applied terms, captures each
// finished sum into a small result FIFO, pulses the MAC clear and back-pressures the source.
module mac_dot_collector #(
    parameter int N          = 16,
    parameter int VEC_LEN    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               mac_o,
    input  logic                       mac_vld,
    output logic                       acc_clr,
    output logic                       stall,
    output logic [N-1:0]               res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(VEC_LEN)-1:0] term_cnt,
    output logic                       err
);
    localparam int CW = $clog2(VEC_LEN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_TERM = CW'(VEC_LEN - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   ONE_CNT   = (PW + 1)'(1);

    typedef enum logic {CLEAR, ACCUM} state_t;

    state_t        state;
    state_t        state_next;
    logic          acc_clr_next;

    logic [N-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_inc;
    logic [PW:0]   count;

    logic          fifo_full;
    logic          accept;
    logic          push;
    logic          pop;

    assign fifo_full  = (count == FULL_CNT);
    assign res_valid  = (count != '0);
    assign rd_ptr_inc = rd_ptr + PW'(1);

    // A term counts only when the source obeyed stall; the last term closes the vector.
    assign accept = (state == ACCUM) && mac_vld && !fifo_full;
    assign push   = accept && (term_cnt == LAST_TERM);
    assign pop    = res_valid && res_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   state_next = ACCUM;
            ACCUM:   if (push) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        stall        = (state == CLEAR) || fifo_full;
        acc_clr_next = (state_next == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_clr <= 1'b1;
        end else begin
            acc_clr <= acc_clr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_cnt <= '0;
        end else if (push) begin
            term_cnt <= '0;
        end else if (accept) begin
            term_cnt <= term_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (mac_vld && stall) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= mac_o;
        end
    end

    // Head register: a push lands here directly when it becomes the only entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
        end else if (push && ((count == '0) || (count == ONE_CNT && pop))) begin
            res_data <= mac_o;
        end else if (pop && (count > ONE_CNT)) begin
            res_data <= mem[rd_ptr_inc];
        end
    end

endmodule

// File: tb/tb_mac_dot_collector.sv
// Directed bench for mac_dot_collector with a behavioural accumulating MAC in front of it.
module tb_mac_dot_collector;
    localparam int N          = 16;
    localparam int VEC_LEN    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(VEC_LEN);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  op_a = '0;
    logic [N-1:0]  op_b = '0;
    logic [N-1:0]  acc;
    logic          mac_rst;
    logic [N-1:0]  mac_o;
    logic          mac_vld = 1'b0;
    logic          acc_clr;
    logic          stall;
    logic [N-1:0]  res_data;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [CW-1:0] term_cnt;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;
    int drain_exp [4] = '{4, 4, 4, 8};

    always #5 clk = ~clk;

    // Upstream MAC: sum is combinational and includes this cycle's term; acc_clr resets it.
    assign mac_rst = rst | acc_clr;
    assign mac_o   = acc + op_a * op_b;
    always @(posedge clk or posedge mac_rst) begin
        if (mac_rst) acc <= '0;
        else         acc <= mac_o;
    end

    mac_dot_collector #(.N(N), .VEC_LEN(VEC_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .mac_o(mac_o), .mac_vld(mac_vld), .acc_clr(acc_clr),
        .stall(stall), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .term_cnt(term_cnt), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic term(input logic [N-1:0] a, input logic [N-1:0] b);
        op_a = a; op_b = b; mac_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic vec(input logic [N-1:0] a, input logic [N-1:0] b);
        repeat (VEC_LEN) term(a, b);
    endtask

    task automatic idle(input int cycles);
        op_a = '0; op_b = '0; mac_vld = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pop_one();
        op_a = '0; op_b = '0; mac_vld = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_acc_clr", acc_clr, 1);
        check("rst_stall", stall, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_term_cnt", term_cnt, 0);
        check("rst_err", err, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b0;
        #1;
        check("rel_c1_acc_clr", acc_clr, 1);
        check("rel_c1_stall", stall, 1);
        @(negedge clk);
        check("rel_c2_acc_clr", acc_clr, 0);
        check("rel_c2_stall", stall, 0);
        check("rel_c2_res_valid", res_valid, 0);

        // Basic dot product: 2+12+30+56 = 100
        term(1, 2); term(3, 4);
        check("t2_term_cnt_mid", term_cnt, 2);
        term(5, 6); term(7, 8);
        check("t2_res_valid", res_valid, 1);
        check("t2_res_data", res_data, 100);
        check("t2_acc_clr_pulse", acc_clr, 1);
        check("t2_stall_clear", stall, 1);
        check("t2_term_cnt_wrap", term_cnt, 0);
        idle(1);
        check("t2_acc_clr_once", acc_clr, 0);
        check("t2_stall_drop", stall, 0);
        check("t2_res_data_hold", res_data, 100);
        pop_one();
        check("t2_empty", res_valid, 0);
        vec(1, 1);
        idle(1);
        check("t2_vec2_data", res_data, 4);
        pop_one();
        check("t2_vec2_empty", res_valid, 0);

        // Modulo wrap: 65536 + 1 + 0 + 6 -> 7
        term(256, 256); term(1, 1); term(0, 0); term(2, 3);
        check("t3_wrap_data", res_data, 7);
        // Term offered during CLEAR: flagged, lost, not counted, not pushed
        term(5, 5);
        check("t5_clear_err", err, 1);
        check("t5_clear_cnt", term_cnt, 0);
        check("t5_clear_head", res_data, 7);
        idle(1);
        check("t5_err_sticky", err, 1);
        pop_one();
        check("t5_clear_no_push", res_valid, 0);
        vec(1, 1);
        idle(1);
        check("t5_clear_term_lost", res_data, 4);
        pop_one();

        // Reset clears the sticky error
        rst = 1'b1;
        @(negedge clk);
        check("rst2_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fill the FIFO with the consumer stalled
        repeat (FIFO_DEPTH) begin
            vec(1, 1);
            idle(1);
        end
        check("t4_full_stall", stall, 1);
        check("t4_full_valid", res_valid, 1);
        check("t4_full_head", res_data, 4);
        term(0, 0);
        check("t5_full_err", err, 1);
        check("t5_full_cnt", term_cnt, 0);
        check("t5_full_stall", stall, 1);
        pop_one();
        check("t4_pop_stall_drop", stall, 0);
        check("t4_pop_valid", res_valid, 1);
        vec(2, 1);
        idle(1);
        check("t4_refull_stall", stall, 1);
        foreach (drain_exp[i]) begin
            check($sformatf("t4_drain_%0d", i), res_data, drain_exp[i]);
            pop_one();
        end
        check("t4_drained", res_valid, 0);
        check("t4_drained_stall", stall, 0);

        // Reset mid-vector with a result pending
        vec(1, 1);
        idle(1);
        term(3, 3); term(3, 3);
        check("t6_mid_cnt", term_cnt, 2);
        op_a = '0; op_b = '0; mac_vld = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_cnt", term_cnt, 0);
        check("t6_rst_empty", res_valid, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_stall", stall, 1);
        check("t6_rst_acc_clr", acc_clr, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec(2, 2);
        idle(1);
        check("t6_after_valid", res_valid, 1);
        check("t6_after_data", res_data, 16);
        pop_one();
        check("t6_after_empty", res_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
